// File: rtl/wb_write_arbiter.sv
// Register-file writeback arbiter: the in-order primary writeback always wins the port,
// long-latency results wait in a small FIFO, and pending results are forwarded to decode.
module wb_write_arbiter #(
    parameter logic [1:0] XLEN  = 2'b10,
    parameter int         DEPTH = 4,
    localparam int        W     = 1 << (32'(XLEN) + 4),
    localparam int        PW    = $clog2(DEPTH),
    localparam int        CW    = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_enable,
    input  logic          i_p_valid,
    input  logic [4:0]    i_p_addr,
    input  logic [W-1:0]  i_p_data,
    input  logic          i_s_valid,
    output logic          o_s_ready,
    input  logic [4:0]    i_s_addr,
    input  logic [W-1:0]  i_s_data,
    output logic          o_reg_write,
    output logic [4:0]    o_wr_addr,
    output logic [W-1:0]  o_wr_data,
    input  logic [4:0]    i_fwd_addr_1,
    input  logic [4:0]    i_fwd_addr_2,
    output logic          o_fwd_hit_1,
    output logic          o_fwd_hit_2,
    output logic [W-1:0]  o_fwd_data_1,
    output logic [W-1:0]  o_fwd_data_2,
    output logic [CW-1:0] o_pending
);

    logic [4:0]       r_addr [DEPTH];
    logic [W-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_s_ready;
    logic             w_p_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_hit_1;
    logic             w_hit_2;
    logic [W-1:0]     w_data_1;
    logic [W-1:0]     w_data_2;

    assign w_s_ready = !i_rst && i_clk_enable && (r_count < CW'(DEPTH));
    assign w_p_fire  = i_p_valid && (i_p_addr != 5'd0);
    // x0 requests are accepted but never occupy a slot
    assign w_push    = i_s_valid && w_s_ready && (i_s_addr != 5'd0);
    assign w_pop     = !w_p_fire && (r_count != CW'(0));

    // FIFO state, kill-on-primary and registered write port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_addr[j] <= 5'd0;
                r_data[j] <= '0;
            end
            r_live      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            o_reg_write <= 1'b0;
            o_wr_addr   <= 5'd0;
            o_wr_data   <= '0;
        end else if (i_clk_enable) begin
            // The primary result is younger than anything queued for the same register
            for (int j = 0; j < DEPTH; j++) begin
                if (w_p_fire && (r_addr[j] == i_p_addr)) begin
                    r_live[j] <= 1'b0;
                end
            end

            if (w_p_fire) begin
                o_reg_write <= 1'b1;
                o_wr_addr   <= i_p_addr;
                o_wr_data   <= i_p_data;
            end else if (w_pop) begin
                o_reg_write    <= r_live[r_rptr];
                o_wr_addr      <= r_addr[r_rptr];
                o_wr_data      <= r_data[r_rptr];
                r_live[r_rptr] <= 1'b0;
                r_rptr         <= r_rptr + PW'(1);
            end else begin
                o_reg_write <= 1'b0;
            end

            if (w_push) begin
                r_addr[r_wptr] <= i_s_addr;
                r_data[r_wptr] <= i_s_data;
                r_live[r_wptr] <= !(w_p_fire && (i_s_addr == i_p_addr));
                r_wptr         <= r_wptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Forwarding lookup: FIFO oldest-to-youngest, then output register, then primary input
    always_comb begin
        logic [PW-1:0] l_idx;
        l_idx    = '0;
        w_hit_1  = 1'b0;
        w_hit_2  = 1'b0;
        w_data_1 = '0;
        w_data_2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            l_idx = r_rptr + PW'(i);
            if ((CW'(i) < r_count) && r_live[l_idx]) begin
                if (r_addr[l_idx] == i_fwd_addr_1) begin
                    w_hit_1  = 1'b1;
                    w_data_1 = r_data[l_idx];
                end else begin
                    w_hit_1  = w_hit_1;
                end
                if (r_addr[l_idx] == i_fwd_addr_2) begin
                    w_hit_2  = 1'b1;
                    w_data_2 = r_data[l_idx];
                end else begin
                    w_hit_2  = w_hit_2;
                end
            end else begin
                l_idx = l_idx;
            end
        end
        if (o_reg_write && (o_wr_addr == i_fwd_addr_1)) begin
            w_hit_1  = 1'b1;
            w_data_1 = o_wr_data;
        end else begin
            w_hit_1  = w_hit_1;
        end
        if (o_reg_write && (o_wr_addr == i_fwd_addr_2)) begin
            w_hit_2  = 1'b1;
            w_data_2 = o_wr_data;
        end else begin
            w_hit_2  = w_hit_2;
        end
        if (i_p_valid && (i_p_addr == i_fwd_addr_1)) begin
            w_hit_1  = 1'b1;
            w_data_1 = i_p_data;
        end else begin
            w_hit_1  = w_hit_1;
        end
        if (i_p_valid && (i_p_addr == i_fwd_addr_2)) begin
            w_hit_2  = 1'b1;
            w_data_2 = i_p_data;
        end else begin
            w_hit_2  = w_hit_2;
        end
        // x0 never hits, and nothing is forwarded while in reset
        if (i_rst || (i_fwd_addr_1 == 5'd0)) begin
            w_hit_1  = 1'b0;
            w_data_1 = '0;
        end else begin
            w_hit_1  = w_hit_1;
        end
        if (i_rst || (i_fwd_addr_2 == 5'd0)) begin
            w_hit_2  = 1'b0;
            w_data_2 = '0;
        end else begin
            w_hit_2  = w_hit_2;
        end
    end

    assign o_s_ready    = w_s_ready;
    assign o_pending    = r_count;
    assign o_fwd_hit_1  = w_hit_1;
    assign o_fwd_hit_2  = w_hit_2;
    assign o_fwd_data_1 = w_data_1;
    assign o_fwd_data_2 = w_data_2;

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Writeback arbiter that drives the single write port of the integer register file from two producers. The primary source is the in-order pipeline writeback and always has priority. The secondary source is the long-latency unit (divider or late load return), which is buffered in a small FIFO. The block also forwards pending, not-yet-written results to the decode-stage read addresses, so no completed result is invisible between production and commit.

## Interface
- XLEN, default `XLEN_64b (2'b10): data width W = 1<<(XLEN+4).
- DEPTH, default 4: secondary FIFO entries; power of two, ≥2.

- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_clk_enable  in  1  global stall; when low, no state changes.
- i_p_valid  in  1  primary write request; no backpressure.
- i_p_addr  in  5  primary destination register.
- i_p_data  in  W  primary data.
- i_s_valid  in  1  secondary write request.
- o_s_ready  out  1  secondary accept.
- i_s_addr  in  5  secondary destination register.
- i_s_data  in  W  secondary data.
- o_reg_write  out  1  register-file write enable (registered).
- o_wr_addr  out  5  register-file write address (registered).
- o_wr_data  out  W  register-file write data (registered).
- i_fwd_addr_1, i_fwd_addr_2  in  5  decode read addresses.
- o_fwd_hit_1, o_fwd_hit_2  out  1  a pending write to that address exists.
- o_fwd_data_1, o_fwd_data_2  out  W  youngest pending data for that address; 0 when no hit.
- o_pending  out  $clog2(DEPTH)+1  valid FIFO occupancy.

## Operation
- Secondary accept: o_s_ready = !i_rst && i_clk_enable && (count < DEPTH). A transfer occurs when i_s_valid && o_s_ready. Readiness never depends on a same-cycle pop, so there is no pass-through when the FIFO is full.
- x0 handling: a secondary request to x0 is accepted and discarded, not enqueued. A primary request to x0 issues no write.
- Issue, per enabled cycle:
  - If i_p_valid && i_p_addr≠0, the output register loads the primary write.
  - Otherwise, if the FIFO head is present, the head is popped. The output register loads it with o_reg_write = the head's live bit.
  - Otherwise o_reg_write <= 0.
- Ordering rule: the primary result is architecturally younger than any queued entry. When a primary write to A≠0 is accepted, every FIFO entry with addr A clears its live bit in the same cycle. This includes an entry being pushed that cycle to A.
- Killed entries are still popped in order and consume an issue slot, but issue no write. o_pending counts occupied slots, including killed ones.
- Forwarding priority, per port, with addr 0 never hitting:
  1. Current primary input (i_p_valid, matching addr).
  2. Output register, when o_reg_write=1 and addresses match.
  3. Youngest live FIFO entry with a matching addr.
  - Forwarding is purely combinational and ignores i_clk_enable.
- Pointers wrap modulo DEPTH. count is tracked separately, so full and empty are never ambiguous.

## Timing
- Reset values: o_reg_write=0, o_wr_addr=0, o_wr_data=0, o_pending=0, FIFO empty with all live bits clear, o_s_ready=0, fwd hits=0, fwd data=0.
- Reset mid-operation discards all queued entries. The write port is idle on the first post-reset cycle.
- Primary latency: 1 cycle, from an enabled edge with i_p_valid to o_reg_write asserted.
- Secondary latency with the FIFO empty and the primary idle: push at edge N, o_reg_write at edge N+1, so the write is visible 2 cycles after the request.
- Secondary starvation: under continuous primary traffic the FIFO never drains. o_s_ready drops once DEPTH entries are held.
- Simultaneous push and pop with count<DEPTH: count is unchanged, and the new entry goes to the tail.
- i_clk_enable low: outputs hold, o_reg_write holds its value, and no push or pop occurs.

## Test plan
- Reset, then primary write x5=0x1234 at cycle 1: o_reg_write=1, o_wr_addr=5, o_wr_data=0x1234 after one edge, then 0 the following cycle.
- With the primary idle, push secondary x3=0xAA and x4=0xBB back-to-back. Expect writes x3 and x4 on consecutive cycles starting 1 cycle after the first push, with o_pending going 1→1→0.
- Hold the primary valid continuously and push 5 secondary entries: o_s_ready drops after 4 accepts, with o_pending=4. Drop the primary and observe 4 in-order writes, then ready reasserts.
- Queue secondary x7=0x11, then primary x7=0x22. Expect a write of x7=0x22, then a killed slot with o_reg_write=0; the final x7 is 0x22.
- Forwarding: queue x9=0x1 then x9=0x2 with the primary busy, and set i_fwd_addr_1=9: hit=1, data=0x2. With i_fwd_addr_2=0, hit=0 even when x0 has been requested.
- Assert i_rst with 3 entries queued: the next cycle shows o_pending=0, o_reg_write=0, and no stale writes afterwards.
